// File: rtl/ex_iter_pkg.sv
// Shared definitions for the execute stage: widths, RV32I opcode and funct3
// encodings, write-back constants, shifter FSM states and a 1-bit shift helper.
package ex_iter_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef logic [XLEN-1:0] reg_bus_t;
  typedef logic [6:0]      alu_op_t;
  typedef logic [2:0]      alu_funct3_t;
  typedef logic [6:0]      alu_funct7_t;
  typedef logic [4:0]      reg_addr_t;

  // RV32I major opcodes
  localparam alu_op_t OP     = 7'b0110011;
  localparam alu_op_t OP_IMM = 7'b0010011;
  localparam alu_op_t LUI    = 7'b0110111;
  localparam alu_op_t AUIPC  = 7'b0010111;
  localparam alu_op_t JAL    = 7'b1101111;
  localparam alu_op_t JALR   = 7'b1100111;

  // funct3 for OP / OP-IMM
  localparam alu_funct3_t F3_ADD_SUB = 3'b000;
  localparam alu_funct3_t F3_SLL     = 3'b001;
  localparam alu_funct3_t F3_SLT     = 3'b010;
  localparam alu_funct3_t F3_SLTU    = 3'b011;
  localparam alu_funct3_t F3_XOR     = 3'b100;
  localparam alu_funct3_t F3_SR      = 3'b101;
  localparam alu_funct3_t F3_OR      = 3'b110;
  localparam alu_funct3_t F3_AND     = 3'b111;

  localparam reg_bus_t  ZERO_WORD     = '0;
  localparam logic      RST_ENABLE    = 1'b1;
  localparam logic      WRITE_ENABLE  = 1'b1;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam reg_addr_t NOP_REG_ADDR  = 5'd0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } shift_state_e;

  // One step of the iterative shifter: right (dir=1) or left (dir=0);
  // arithmetic right shifts replicate the sign bit.
  function automatic reg_bus_t shift1(reg_bus_t v, logic dir, logic arith);
    if (dir) return {arith & v[XLEN-1], v[XLEN-1:1]};
    return {v[XLEN-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/ex_iter_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. The master side is the pipeline
// (ID/EX register, branch unit, EX/MEM register, ctrl); the slave side is ex_iter.
interface ex_iter_if;
  import ex_iter_pkg::*;

  reg_bus_t    ex_pc;
  alu_op_t     ex_aluop;
  alu_funct3_t ex_alufunct3;
  alu_funct7_t ex_alufunct7;
  reg_bus_t    ex_reg1;
  reg_bus_t    ex_reg2;
  reg_bus_t    ex_imm;
  logic        ex_wreg;
  reg_addr_t   ex_wd;
  logic        flush_i;

  reg_addr_t   wd_o;
  logic        wreg_o;
  reg_bus_t    wdata_o;
  logic        stallreq_o;

  modport master (
    output ex_pc, ex_aluop, ex_alufunct3, ex_alufunct7,
           ex_reg1, ex_reg2, ex_imm, ex_wreg, ex_wd, flush_i,
    input  wd_o, wreg_o, wdata_o, stallreq_o
  );

  modport slave (
    input  ex_pc, ex_aluop, ex_alufunct3, ex_alufunct7,
           ex_reg1, ex_reg2, ex_imm, ex_wreg, ex_wd, flush_i,
    output wd_o, wreg_o, wdata_o, stallreq_o
  );

endinterface

// File: rtl/ex_shift_iter.sv
// Bit-serial shifter: one bit per cycle. A start with nonzero shamt in IDLE
// performs the first step immediately, so a shift by k finishes k cycles later
// (done_o high for one cycle with result_o valid). flush_i abandons the shift.
module ex_shift_iter
  import ex_iter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               start_i,
  input  logic               dir_i,
  input  logic               arith_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  reg_bus_t           op_i,
  output logic               busy_o,
  output logic               done_o,
  output reg_bus_t           result_o
);

  shift_state_e       state_q;
  reg_bus_t           acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               arith_q;
  logic               dir_q;

  logic idle;
  logic launch;
  logic cnt_zero;

  assign idle     = (state_q == S_IDLE);
  assign cnt_zero = (cnt_q == '0);
  assign launch   = idle && start_i && (shamt_i != '0);

  assign busy_o   = !flush_i && (launch || (!idle && !cnt_zero));
  assign done_o   = !flush_i && !idle && cnt_zero;
  assign result_o = acc_q;

  // Shifter FSM: launch with the first step, then step until cnt reaches zero.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      // NOTE: the accumulator is cleared too so a reset mid-shift leaves no stale data visible as result_o.
      state_q <= S_IDLE;
      acc_q   <= ZERO_WORD;
      cnt_q   <= '0;
      arith_q <= 1'b0;
      dir_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            acc_q   <= shift1(op_i, dir_i, arith_i);
            cnt_q   <= shamt_i - SHAMT_W'(1);
            arith_q <= arith_i;
            dir_q   <= dir_i;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!cnt_zero) begin
            acc_q <= shift1(acc_q, dir_q, arith_q);
            cnt_q <= cnt_q - SHAMT_W'(1);
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_iter.sv
// RV32I execute stage. Single-cycle ALU results plus an iterative shifter that
// stalls upstream while it runs. Define EX_BARREL_SHIFT_EN to replace the
// iterative shifter with a combinational barrel shifter (never stalls).
module ex_iter
  import ex_iter_pkg::*;
(
  input logic   clk,
  input logic   rst,
  ex_iter_if.slave bus
);

  logic               is_op;
  logic               is_opimm;
  logic               is_shift;
  logic               shift_right;
  logic               shift_arith;
  logic [SHAMT_W-1:0] shamt;
  reg_bus_t           op1;
  reg_bus_t           op2;
  reg_bus_t           shift_res;
  reg_bus_t           alu_res;
  logic               alu_wr;

  logic               shift_busy;
  logic               shift_done;
  reg_bus_t           shift_result;

  assign is_op       = (bus.ex_aluop == OP);
  assign is_opimm    = (bus.ex_aluop == OP_IMM);
  assign op1         = bus.ex_reg1;
  assign op2         = is_op ? bus.ex_reg2 : bus.ex_imm;
  assign shamt       = op2[SHAMT_W-1:0];
  assign shift_right = (bus.ex_alufunct3 == F3_SR);
  assign shift_arith = bus.ex_alufunct7[5];
  assign is_shift    = (is_op || is_opimm) &&
                       ((bus.ex_alufunct3 == F3_SLL) || (bus.ex_alufunct3 == F3_SR));

  logic unused_funct7;
  assign unused_funct7 = ^{bus.ex_alufunct7[6], bus.ex_alufunct7[4:0]};

`ifdef EX_BARREL_SHIFT_EN
  logic signed [XLEN-1:0] op1_s;
  assign op1_s = op1;

  // Barrel shifter: full result in the same cycle.
  always_comb begin
    if (!shift_right)     shift_res = op1 << shamt;
    else if (shift_arith) shift_res = op1_s >>> shamt;
    else                  shift_res = op1 >> shamt;
  end

  assign shift_busy   = 1'b0;
  assign shift_done   = 1'b0;
  assign shift_result = ZERO_WORD;

  logic unused_clk;
  assign unused_clk = clk;
`else
  // In IDLE the ALU path only reaches a shift when shamt is zero: result is op1.
  assign shift_res = op1;

  ex_shift_iter u_shift (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (bus.flush_i),
    .start_i  (is_shift),
    .dir_i    (shift_right),
    .arith_i  (shift_arith),
    .shamt_i  (shamt),
    .op_i     (op1),
    .busy_o   (shift_busy),
    .done_o   (shift_done),
    .result_o (shift_result)
  );
`endif

  // Single-cycle ALU: result and whether the opcode writes a register.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    alu_res = ZERO_WORD;
    alu_wr  = WRITE_DISABLE;
    unique case (bus.ex_aluop)
      OP, OP_IMM: begin
        alu_wr = WRITE_ENABLE;
        unique case (bus.ex_alufunct3)
          F3_ADD_SUB: alu_res = (is_op && bus.ex_alufunct7[5]) ? op1 - op2 : op1 + op2;
          F3_SLT:     alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
          F3_SLTU:    alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
          F3_XOR:     alu_res = op1 ^ op2;
          F3_OR:      alu_res = op1 | op2;
          F3_AND:     alu_res = op1 & op2;
          F3_SLL,
          F3_SR:      alu_res = shift_res;
          default:    alu_res = ZERO_WORD;
        endcase
      end
      LUI:       begin alu_wr = WRITE_ENABLE; alu_res = bus.ex_imm; end
      AUIPC:     begin alu_wr = WRITE_ENABLE; alu_res = bus.ex_pc + bus.ex_imm; end
      JAL, JALR: begin alu_wr = WRITE_ENABLE; alu_res = bus.ex_pc + 32'd4; end
      default:   begin alu_wr = WRITE_DISABLE; alu_res = ZERO_WORD; end
    endcase
  end

  // Write-back tuple and stall request: reset > flush > shift busy > shift done > ALU.
  always_comb begin
    bus.wd_o       = bus.ex_wd;
    bus.wreg_o     = alu_wr ? bus.ex_wreg : WRITE_DISABLE;
    bus.wdata_o    = alu_res;
    bus.stallreq_o = 1'b0;
    if (rst == RST_ENABLE) begin
      bus.wd_o    = NOP_REG_ADDR;
      bus.wreg_o  = WRITE_DISABLE;
      bus.wdata_o = ZERO_WORD;
    end else if (bus.flush_i) begin
      bus.wreg_o  = WRITE_DISABLE;
      bus.wdata_o = ZERO_WORD;
    end else if (shift_busy) begin
      bus.wreg_o     = WRITE_DISABLE;
      bus.wdata_o    = ZERO_WORD;
      bus.stallreq_o = 1'b1;
    end else if (shift_done) begin
      bus.wreg_o  = bus.ex_wreg;
      bus.wdata_o = shift_result;
    end
  end

endmodule

// File: tb/tb_ex_iter.sv
// Directed self-checking bench for ex_iter. Inputs change 1 time unit after
// posedge; outputs are checked on negedge. Expected stall counts become zero
// when EX_BARREL_SHIFT_EN is defined.
module tb_ex_iter;
  import ex_iter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_iter_if bus ();

  ex_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int exp_stalls(input int k);
`ifdef EX_BARREL_SHIFT_EN
    return 0;
`else
    return k;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] data, input logic wreg,
                           input logic [4:0] wd, input logic stall);
    check({tag, "_wdata"}, bus.wdata_o, data);
    check({tag, "_wreg"},  32'(bus.wreg_o), 32'(wreg));
    check({tag, "_wd"},    32'(bus.wd_o), 32'(wd));
    check({tag, "_stall"}, 32'(bus.stallreq_o), 32'(stall));
  endtask

  task automatic drive(input logic [6:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic wreg, input logic [4:0] wd);
    bus.ex_aluop     = aluop;
    bus.ex_alufunct3 = f3;
    bus.ex_alufunct7 = f7;
    bus.ex_reg1      = r1;
    bus.ex_reg2      = r2;
    bus.ex_imm       = imm;
    bus.ex_pc        = pc;
    bus.ex_wreg      = wreg;
    bus.ex_wd        = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Follows a shift presented this cycle until stallreq_o drops; checks the
  // stall count, wreg_o low while stalling, and the final write-back tuple.
  task automatic run_shift(input string tag, input int k, input logic [31:0] res,
                           input logic [4:0] wd);
    int stalls   = 0;
    int bad_wreg = 0;
    bit done     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.stallreq_o === 1'b1) begin
        stalls++;
        if (bus.wreg_o !== 1'b0) bad_wreg++;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    check({tag, "_finished"}, 32'(done), 32'd1);
    check({tag, "_stalls"}, stalls, exp_stalls(k));
    check({tag, "_wreg_during_stall"}, bad_wreg, 32'd0);
    check_out(tag, res, 1'b1, wd, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.flush_i = 1'b0;
    drive(OP, F3_ADD_SUB, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1, 5'd3);

    // Reset forces all outputs to zero even with a live ADD on the inputs.
    @(negedge clk);
    check_out("reset", 32'd0, 1'b0, 5'd0, 1'b0);
    next_cycle();
    rst = 1'b0;

    // ADD / SUB
    @(negedge clk);
    check_out("add", 32'd12, 1'b1, 5'd3, 1'b0);
    next_cycle();
    drive(OP, F3_ADD_SUB, 7'h20, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1, 5'd3);
    @(negedge clk);
    check_out("sub", 32'hFFFF_FFFE, 1'b1, 5'd3, 1'b0);

    // Compares and logic ops
    next_cycle();
    drive(OP, F3_SLT, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 5'd1);
    @(negedge clk);
    check("slt_wdata", bus.wdata_o, 32'd1);
    next_cycle();
    drive(OP, F3_SLTU, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 5'd1);
    @(negedge clk);
    check("sltu_wdata", bus.wdata_o, 32'd0);
    next_cycle();
    drive(OP_IMM, F3_SLT, 7'h7F, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd2);
    @(negedge clk);
    check("slti_wdata", bus.wdata_o, 32'd1);
    next_cycle();
    drive(OP_IMM, F3_AND, 7'h00, 32'h0000_F0F0, 32'd0, 32'h0000_00FF, 32'd0, 1'b1, 5'd2);
    @(negedge clk);
    check("andi_wdata", bus.wdata_o, 32'h0000_00F0);
    next_cycle();
    drive(OP, F3_XOR, 7'h00, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'd0, 1'b1, 5'd2);
    @(negedge clk);
    check("xor_wdata", bus.wdata_o, 32'hF0F0_F0F0);

    // SRAI by 4, then back-to-back SLLI by 31 (worst case)
    next_cycle();
    drive(OP_IMM, F3_SR, 7'h20, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b1, 5'd4);
    run_shift("srai4", 4, 32'hF800_0000, 5'd4);
    next_cycle();
    drive(OP_IMM, F3_SLL, 7'h00, 32'd1, 32'd0, 32'd31, 32'd0, 1'b1, 5'd5);
    run_shift("slli31", 31, 32'h8000_0000, 5'd5);

    // SLL by zero: upper rs2 bits are not part of shamt
    next_cycle();
    drive(OP, F3_SLL, 7'h00, 32'hDEAD_BEEF, 32'h0000_0020, 32'd0, 32'd0, 1'b1, 5'd6);
    @(negedge clk);
    check_out("sll0", 32'hDEAD_BEEF, 1'b1, 5'd6, 1'b0);

    // AUIPC / JAL / JALR / LUI
    next_cycle();
    drive(AUIPC, 3'd0, 7'h00, 32'd0, 32'd0, 32'h0000_1000, 32'h0000_0100, 1'b1, 5'd7);
    @(negedge clk);
    check_out("auipc", 32'h0000_1100, 1'b1, 5'd7, 1'b0);
    next_cycle();
    drive(JAL, 3'd0, 7'h00, 32'd0, 32'd0, 32'h0000_0040, 32'h0000_0200, 1'b1, 5'd1);
    @(negedge clk);
    check("jal_wdata", bus.wdata_o, 32'h0000_0204);
    next_cycle();
    drive(JALR, 3'd0, 7'h00, 32'h1234, 32'd0, 32'd8, 32'h0000_0300, 1'b1, 5'd1);
    @(negedge clk);
    check("jalr_wdata", bus.wdata_o, 32'h0000_0304);
    next_cycle();
    drive(LUI, 3'd0, 7'h00, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 1'b1, 5'd0);
    @(negedge clk);
    check_out("lui_x0", 32'h1234_5000, 1'b1, 5'd0, 1'b0);

    // Flush in the third stall cycle of SRL by 10
    next_cycle();
    drive(OP, F3_SR, 7'h00, 32'hF000_0000, 32'd10, 32'd0, 32'd0, 1'b1, 5'd6);
`ifndef EX_BARREL_SHIFT_EN
    @(negedge clk);
    check("flush_stall1", 32'(bus.stallreq_o), 32'd1);
    next_cycle();
    @(negedge clk);
    check("flush_stall2", 32'(bus.stallreq_o), 32'd1);
    next_cycle();
`endif
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_stall", 32'(bus.stallreq_o), 32'd0);
    check("flush_wreg", 32'(bus.wreg_o), 32'd0);
    next_cycle();
    bus.flush_i = 1'b0;
    drive(OP, F3_ADD_SUB, 7'h00, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 5'd7);
    @(negedge clk);
    check_out("post_flush_add", 32'd7, 1'b1, 5'd7, 1'b0);
    next_cycle();
    drive(OP_IMM, F3_SR, 7'h00, 32'h0000_0010, 32'd0, 32'd1, 32'd0, 1'b1, 5'd8);
    run_shift("post_flush_srli1", 1, 32'h0000_0008, 5'd8);

    // Flush in IDLE kills a single-cycle result
    next_cycle();
    drive(OP, F3_OR, 7'h00, 32'h0F, 32'hF0, 32'd0, 32'd0, 1'b1, 5'd9);
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("idle_flush_wreg", 32'(bus.wreg_o), 32'd0);
    check("idle_flush_stall", 32'(bus.stallreq_o), 32'd0);
    next_cycle();
    bus.flush_i = 1'b0;

    // Reset during SHIFT
    drive(OP, F3_SLL, 7'h00, 32'd1, 32'd20, 32'd0, 32'd0, 1'b1, 5'd8);
`ifndef EX_BARREL_SHIFT_EN
    @(negedge clk);
    check("rst_shift_stall1", 32'(bus.stallreq_o), 32'd1);
    next_cycle();
    @(negedge clk);
    check("rst_shift_stall2", 32'(bus.stallreq_o), 32'd1);
    next_cycle();
`endif
    rst = 1'b1;
    @(negedge clk);
    check_out("rst_mid_shift", 32'd0, 1'b0, 5'd0, 1'b0);
    next_cycle();
    rst = 1'b0;
    drive(OP, F3_ADD_SUB, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0, 1'b1, 5'd9);
    @(negedge clk);
    check_out("post_rst_add", 32'd30, 1'b1, 5'd9, 1'b0);
    next_cycle();
    drive(OP_IMM, F3_SR, 7'h00, 32'h0000_0100, 32'd0, 32'd2, 32'd0, 1'b1, 5'd10);
    run_shift("post_rst_srli2", 2, 32'h0000_0040, 5'd10);

    // Non-ALU opcodes never write back
    next_cycle();
    drive(7'b0100011, 3'b010, 7'h00, 32'd5, 32'd6, 32'd8, 32'h400, 1'b1, 5'd9);
    @(negedge clk);
    check("store_wreg", 32'(bus.wreg_o), 32'd0);
    check("store_wdata", bus.wdata_o, 32'd0);
    check("store_stall", 32'(bus.stallreq_o), 32'd0);
    next_cycle();
    drive(7'b0000000, 3'b000, 7'h00, 32'd5, 32'd6, 32'd8, 32'h404, 1'b1, 5'd9);
    @(negedge clk);
    check("nop_wreg", 32'(bus.wreg_o), 32'd0);
    check("nop_wdata", bus.wdata_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
